blink_stretcher: RTL and testbench

- Output-side counterpart to the cape's switch input conditioning. Input conditioning removes short transitions arriving from a pin; this block guarantees that transitions driven onto a pin last a minimum time.
- Converts single-cycle event strobes from fabric logic (e.g. a debounced switch edge or a motor fault) into LED blinks a human can see.
- Each blink has a guaranteed on-time, followed by a guaranteed off-gap.
- Events that arrive during a blink are queued, so that each event produces one distinct blink.

---
 rtl/blink_stretcher_if.sv | 21 ++
 rtl/blink_stretcher.sv | 128 ++++++++++++
 tb/tb_blink_stretcher.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/blink_stretcher_if.sv
// Event/status bus between fabric logic (master) and the blink stretcher (slave).
interface blink_stretcher_if #(
  parameter int PEND_WIDTH = 3
);
  logic                  event_in;
  logic                  clear_ovf;
  logic                  led_out;
  logic                  busy;
  logic [PEND_WIDTH-1:0] pending;
  logic                  overflow;

  modport master (
    output event_in, clear_ovf,
    input  led_out, busy, pending, overflow
  );

  modport slave (
    input  event_in, clear_ovf,
    output led_out, busy, pending, overflow
  );
endinterface

// File: rtl/blink_stretcher.sv
// Stretches single-cycle event strobes into visible LED blinks with a
// guaranteed on-time and off-gap, queueing events that arrive mid-blink.
module blink_stretcher #(
  parameter int COUNT_WIDTH = 16,
  parameter int ON_CYCLES   = 32767,
  parameter int GAP_CYCLES  = 32767,
  parameter int PEND_WIDTH  = 3
) (
  input  logic             clk,
  input  logic             reset,
  blink_stretcher_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ON_LOAD   = COUNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] GAP_LOAD  = COUNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMER_ONE = COUNT_WIDTH'(1);
  localparam logic [PEND_WIDTH-1:0]  PEND_ONE  = PEND_WIDTH'(1);
  localparam logic [PEND_WIDTH-1:0]  PEND_MAX  = {PEND_WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] timer_q, timer_d;
  logic [PEND_WIDTH-1:0]  pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic                   led_q;
  logic                   busy_q;

  logic                   take_direct;
  logic                   take_queued;
  logic                   enqueue;
  logic                   drop;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    take_direct = 1'b0;
    take_queued = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.event_in) begin
          state_d     = ST_ON;
          timer_d     = ON_LOAD;
          take_direct = 1'b1;
        end
      end
      ST_ON: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_ONE;
        end else begin
          state_d = ST_GAP;
          timer_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_ONE;
        end else if (pending_q != '0) begin
          // Queued events are served before a strobe arriving this same cycle.
          state_d     = ST_ON;
          timer_d     = ON_LOAD;
          take_queued = 1'b1;
        end else if (bus.event_in) begin
          state_d     = ST_ON;
          timer_d     = ON_LOAD;
          take_direct = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    enqueue   = bus.event_in && !take_direct && (state_q != ST_IDLE);
    pending_d = pending_q;
    drop      = 1'b0;

    unique case ({enqueue, take_queued})
      2'b10: begin
        if (pending_q == PEND_MAX) drop = 1'b1;
        else                       pending_d = pending_q + PEND_ONE;
      end
      2'b01:   pending_d = pending_q - PEND_ONE;
      default: pending_d = pending_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)               overflow_d = 1'b1;
    else if (bus.clear_ovf) overflow_d = 1'b0;
    else                    overflow_d = overflow_q;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      led_q      <= (state_d == ST_ON);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign bus.led_out  = led_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_blink_stretcher.sv
// Directed bench: dut_a uses ON=4/GAP=3, dut_b uses ON=1/GAP=1, both PEND_WIDTH=2.
module tb_blink_stretcher;

  logic clk = 1'b0;
  logic reset;
  logic ev;
  logic clr;

  int n_checks = 0;
  int n_pass   = 0;
  int blinks;
  int max_pend;
  logic prev_led;

  always #5 clk = ~clk;

  blink_stretcher_if #(.PEND_WIDTH(2)) a_if ();
  blink_stretcher_if #(.PEND_WIDTH(2)) b_if ();

  assign a_if.event_in  = ev;
  assign a_if.clear_ovf = clr;
  assign b_if.event_in  = ev;
  assign b_if.clear_ovf = clr;

  blink_stretcher #(
    .COUNT_WIDTH(16), .ON_CYCLES(4), .GAP_CYCLES(3), .PEND_WIDTH(2)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (a_if)
  );

  blink_stretcher #(
    .COUNT_WIDTH(16), .ON_CYCLES(1), .GAP_CYCLES(1), .PEND_WIDTH(2)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (b_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // Drive inputs for one cycle; on return the outputs show the next cycle.
  task automatic step(input logic e, input logic c);
    ev  = e;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ev    = 1'b0;
    clr   = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_led",  a_if.led_out,  0);
    check("rst_busy", a_if.busy,     0);
    check("rst_pend", a_if.pending,  0);
    check("rst_ovf",  a_if.overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0);
    step(0, 0);

    // Test 1: single pulse in cycle 10
    for (int c = 10; c <= 18; c++) begin
      int o;
      o = c + 1;
      step(c == 10, 0);
      check($sformatf("t1_led_c%0d", o),  a_if.led_out, (o >= 11 && o <= 14));
      check($sformatf("t1_busy_c%0d", o), a_if.busy,    (o <= 17));
      check($sformatf("t1_pend_c%0d", o), a_if.pending, 0);
    end

    // Test 2: pulses in cycles 10, 12, 13
    for (int c = 10; c <= 31; c++) begin
      int o;
      int ep;
      o  = c + 1;
      ep = (o == 13) ? 1 : (o >= 14 && o <= 17) ? 2 : (o >= 18 && o <= 24) ? 1 : 0;
      step(c == 10 || c == 12 || c == 13, 0);
      check($sformatf("t2_led_c%0d", o),
            a_if.led_out, (o >= 11 && o <= 14) || (o >= 18 && o <= 21) || (o >= 25 && o <= 28));
      check($sformatf("t2_busy_c%0d", o), a_if.busy,    (o <= 31));
      check($sformatf("t2_pend_c%0d", o), a_if.pending, ep);
    end

    // Test 3: event_in held for cycles 10..16, clear_ovf collides with a drop at 15
    blinks   = 0;
    prev_led = 1'b0;
    for (int c = 10; c <= 44; c++) begin
      int o;
      o = c + 1;
      step(c >= 10 && c <= 16, c == 15);
      if (a_if.led_out && !prev_led) blinks++;
      prev_led = a_if.led_out;
      if (o == 14) begin
        check("t3_pend_sat", a_if.pending,  3);
        check("t3_ovf_pre",  a_if.overflow, 0);
      end
      if (o == 15) check("t3_ovf_set",   a_if.overflow, 1);
      if (o == 16) check("t3_set_wins",  a_if.overflow, 1);
      if (o == 18) check("t3_pend_dec",  a_if.pending,  2);
    end
    check("t3_blinks",    blinks,        4);
    check("t3_idle",      a_if.busy,     0);
    check("t3_pend_end",  a_if.pending,  0);
    check("t3_ovf_stick", a_if.overflow, 1);
    step(0, 1);
    check("t3_ovf_clr",   a_if.overflow, 0);
    step(0, 0);

    // Test 4: pulse in the last GAP cycle chains straight into a new blink
    for (int c = 10; c <= 25; c++) begin
      int o;
      o = c + 1;
      step(c == 10 || c == 17, 0);
      check($sformatf("t4_led_c%0d", o),
            a_if.led_out, (o >= 11 && o <= 14) || (o >= 18 && o <= 21));
      check($sformatf("t4_busy_c%0d", o), a_if.busy,    (o <= 24));
      check($sformatf("t4_pend_c%0d", o), a_if.pending, 0);
    end

    // Test 5: asynchronous reset in the middle of ON with events queued
    step(1, 0);
    step(1, 0);
    step(1, 0);
    check("t5_pre_led",  a_if.led_out, 1);
    check("t5_pre_pend", a_if.pending, 2);
    ev = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_led",  a_if.led_out, 0);
    check("t5_async_busy", a_if.busy,    0);
    check("t5_async_pend", a_if.pending, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0);
    for (int c = 10; c <= 18; c++) begin
      int o;
      o = c + 1;
      step(c == 10, 0);
      check($sformatf("t5_led_c%0d", o),  a_if.led_out, (o >= 11 && o <= 14));
      check($sformatf("t5_busy_c%0d", o), a_if.busy,    (o <= 17));
    end

    // Test 6: ON=1, GAP=1, two back-to-back pulses
    max_pend = 0;
    for (int c = 10; c <= 15; c++) begin
      int o;
      o = c + 1;
      step(c == 10 || c == 11, 0);
      if (int'(b_if.pending) > max_pend) max_pend = int'(b_if.pending);
      check($sformatf("t6_led_c%0d", o),  b_if.led_out, (o == 11 || o == 13));
      check($sformatf("t6_busy_c%0d", o), b_if.busy,    (o <= 14));
      check($sformatf("t6_pend_c%0d", o), b_if.pending, (o == 12));
    end
    check("t6_pend_peak", max_pend, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
